// File: rtl/div_iter_ctrl_pkg.sv
// Shared constants and state type for the iterative div/sqrt mantissa divider.
package fpu_defs_div_sqrt;

    localparam int C_MANT   = 52;
    localparam int C_REM_W  = C_MANT + 3;
    localparam int C_ITER_W = 6;
    localparam int C_QUOT_W = C_MANT + 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_iter_ctrl_if.sv
// Handshake/operand/result bundle between the pre-normalisation, divider and rounding stages.
// Precision_ctl_SI exists only when DIV_ITER_PRECISION_CTL_EN is defined.
interface div_iter_ctrl_if;
    import fpu_defs_div_sqrt::*;

    logic                Start_SI;
    logic                Kill_SI;
    logic [C_MANT:0]     Mant_a_DI;
    logic [C_MANT:0]     Mant_b_DI;
`ifdef DIV_ITER_PRECISION_CTL_EN
    logic [5:0]          Precision_ctl_SI;
`endif
    logic                Ready_SO;
    logic                Done_SO;
    logic [C_MANT+1:0]   Quotient_DO;
    logic                Sticky_SO;

`ifdef DIV_ITER_PRECISION_CTL_EN
    modport master (
        output Start_SI, Kill_SI, Mant_a_DI, Mant_b_DI, Precision_ctl_SI,
        input  Ready_SO, Done_SO, Quotient_DO, Sticky_SO
    );

    modport slave (
        input  Start_SI, Kill_SI, Mant_a_DI, Mant_b_DI, Precision_ctl_SI,
        output Ready_SO, Done_SO, Quotient_DO, Sticky_SO
    );
`else
    modport master (
        output Start_SI, Kill_SI, Mant_a_DI, Mant_b_DI,
        input  Ready_SO, Done_SO, Quotient_DO, Sticky_SO
    );

    modport slave (
        input  Start_SI, Kill_SI, Mant_a_DI, Mant_b_DI,
        output Ready_SO, Done_SO, Quotient_DO, Sticky_SO
    );
`endif

endinterface

// File: rtl/div_iter_step.sv
// One non-restoring division step: shift the partial remainder, add +/-D, derive the quotient bit.
module div_iter_step
    import fpu_defs_div_sqrt::*;
(
    input  logic [C_REM_W-1:0] rem,
    input  logic [C_REM_W-1:0] divisor,
    input  logic [C_REM_W-1:0] neg_divisor,
    input  logic               first_step,
    output logic [C_REM_W-1:0] rem_next,
    output logic               q_bit
);

    logic [C_REM_W-1:0] shifted;
    logic [C_REM_W-1:0] addend;

    // The first step only aligns the dividend against D; afterwards the sign of R picks +D or -D.
    always_comb begin
        shifted  = first_step ? rem : {rem[C_REM_W-2:0], 1'b0};
        addend   = (first_step || !rem[C_REM_W-1]) ? neg_divisor : divisor;
        rem_next = shifted + addend;
        q_bit    = ~rem_next[C_REM_W-1];
    end

endmodule

// File: rtl/div_iter_ctrl.sv
// Iteration controller for non-restoring mantissa division, one quotient bit per cycle.
// Define DIV_ITER_PRECISION_CTL_EN to shorten the iteration count via Precision_ctl_SI.
module div_iter_ctrl
    import fpu_defs_div_sqrt::*;
(
    input  logic            Clk_CI,
    input  logic            Rst_RBI,
    div_iter_ctrl_if.slave  bus
);

    div_state_t            state_q, state_d;
    logic                  accept;
    logic                  finish;
    logic                  step_en;
    logic                  first_step;

    logic [C_REM_W-1:0]    rem_q;
    logic [C_REM_W-1:0]    div_q;
    logic [C_REM_W-1:0]    neg_div_q;
    logic [C_REM_W-1:0]    rem_next;
    logic [C_REM_W-1:0]    mant_a_ext;
    logic [C_REM_W-1:0]    mant_b_ext;
    logic                  q_bit;
    logic                  sticky_next;

    logic [C_QUOT_W-2:0]   quot_q;
    logic [C_QUOT_W-1:0]   quot_full;
    logic [C_QUOT_W-1:0]   quot_aligned;
    logic [C_QUOT_W-1:0]   quot_out_q;
    logic                  sticky_q;

    logic [C_ITER_W-1:0]   cnt_q;
    logic [C_ITER_W-1:0]   last_q;
    logic [C_ITER_W-1:0]   last_d;

    assign mant_a_ext  = {2'b00, bus.Mant_a_DI};
    assign mant_b_ext  = {2'b00, bus.Mant_b_DI};
    assign first_step  = (cnt_q == '0);
    assign quot_full   = {quot_q, q_bit};
    assign sticky_next = (rem_next != '0) && (rem_next != neg_div_q);

    div_iter_step u_step (
        .rem         (rem_q),
        .divisor     (div_q),
        .neg_divisor (neg_div_q),
        .first_step  (first_step),
        .rem_next    (rem_next),
        .q_bit       (q_bit)
    );

`ifdef DIV_ITER_PRECISION_CTL_EN
    // Precision requests above the mantissa width saturate; short results are left-aligned.
    always_comb begin
        last_d = C_ITER_W'(C_MANT + 1);
        if (bus.Precision_ctl_SI < C_ITER_W'(C_MANT)) begin
            last_d = bus.Precision_ctl_SI + C_ITER_W'(1);
        end
        quot_aligned = quot_full << (C_ITER_W'(C_QUOT_W - 1) - last_q);
    end
`else
    assign last_d       = C_ITER_W'(C_MANT + 1);
    assign quot_aligned = quot_full;
`endif

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Kill overrides everything, including a simultaneous start and the final step.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start_SI && !bus.Kill_SI) begin
                    state_d = BUSY;
                    accept  = 1'b1;
                end
            end
            BUSY: begin
                if (bus.Kill_SI) begin
                    state_d = IDLE;
                end else if (cnt_q == last_q) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign step_en = (state_q == BUSY) && !bus.Kill_SI;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            rem_q      <= '0;
            div_q      <= '0;
            neg_div_q  <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            quot_out_q <= '0;
            sticky_q   <= 1'b0;
        end else if (accept) begin
            rem_q     <= mant_a_ext;
            div_q     <= mant_b_ext;
            neg_div_q <= -mant_b_ext;
            quot_q    <= '0;
            cnt_q     <= '0;
            last_q    <= last_d;
        end else if (step_en) begin
            rem_q  <= rem_next;
            quot_q <= quot_full[C_QUOT_W-2:0];
            cnt_q  <= cnt_q + C_ITER_W'(1);
            if (finish) begin
                quot_out_q <= quot_aligned;
                sticky_q   <= sticky_next;
            end
        end
    end

    assign bus.Ready_SO    = (state_q == IDLE);
    assign bus.Done_SO     = (state_q == DONE);
    assign bus.Quotient_DO = quot_out_q;
    assign bus.Sticky_SO   = sticky_q;

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Randomised self-checking bench for div_iter_ctrl against an integer-division reference.
// Exercises the Precision_ctl_SI path when DIV_ITER_PRECISION_CTL_EN is defined.
module tb_div_iter_ctrl;
    import fpu_defs_div_sqrt::*;

    localparam logic [C_MANT:0] ONE      = 53'h10000000000000;
    localparam logic [C_MANT:0] ONE_HALF = 53'h18000000000000;

    logic clk = 1'b0;
    logic rst_n;

    div_iter_ctrl_if bus ();

    div_iter_ctrl dut (
        .Clk_CI  (clk),
        .Rst_RBI (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int compare_count = 0;
    int fail_count    = 0;

    logic [C_QUOT_W-1:0] last_quot;
    logic                last_sticky;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compare_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [C_MANT:0] randMant();
        return {1'b1, 20'($urandom), 32'($urandom)};
    endfunction

    // Reference: quotient = floor(a * 2^(n-1) / b) left-aligned to the output width, sticky = inexact.
    function automatic void modelDivide(input logic [C_MANT:0] a, input logic [C_MANT:0] b, input int n,
                                        output logic [C_QUOT_W-1:0] q, output logic s);
        logic [127:0] num;
        logic [127:0] den;
        logic [127:0] quo;
        logic [127:0] rem;
        num = {75'd0, a} << (n - 1);
        den = {75'd0, b};
        quo = num / den;
        rem = num % den;
        q   = C_QUOT_W'(quo << (C_QUOT_W - n));
        s   = (rem != 128'd0);
    endfunction

`ifdef DIV_ITER_PRECISION_CTL_EN
    logic [5:0] prec;

    function automatic int iterFor(input logic [5:0] p);
        return ((int'(p) > C_MANT) ? C_MANT : int'(p)) + 2;
    endfunction
`endif

    // Runs one divide from the current (idle) cycle; optionally pulses Start once while busy.
    task automatic applyStimulus(input string tag, input logic [C_MANT:0] a, input logic [C_MANT:0] b,
                                 input int n, input int busy_start_at);
        logic [C_QUOT_W-1:0] exp_q;
        logic                exp_s;
        int                  cycles;
        modelDivide(a, b, n, exp_q, exp_s);
        checkOutput({tag, " ready_before"}, 64'(bus.Ready_SO), 64'd1);
        bus.Mant_a_DI = a;
        bus.Mant_b_DI = b;
        bus.Start_SI  = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            bus.Start_SI  = (cycles == busy_start_at);
            bus.Mant_a_DI = randMant();
            bus.Mant_b_DI = randMant();
        end while (!bus.Done_SO && cycles < 200);
        bus.Start_SI = 1'b0;
        checkOutput({tag, " latency"}, 64'(cycles), 64'(n + 1));
        checkOutput({tag, " quotient"}, 64'(bus.Quotient_DO), 64'(exp_q));
        checkOutput({tag, " sticky"}, 64'(bus.Sticky_SO), 64'(exp_s));
        @(posedge clk);
        #1;
        checkOutput({tag, " done_pulse"}, 64'(bus.Done_SO), 64'd0);
        checkOutput({tag, " ready_after"}, 64'(bus.Ready_SO), 64'd1);
        last_quot   = exp_q;
        last_sticky = exp_s;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int done_seen;
        logic [C_MANT:0] a;
        logic [C_MANT:0] b;

        rst_n         = 1'b0;
        bus.Start_SI  = 1'b0;
        bus.Kill_SI   = 1'b0;
        bus.Mant_a_DI = '0;
        bus.Mant_b_DI = '0;
`ifdef DIV_ITER_PRECISION_CTL_EN
        prec = 6'd52;
        bus.Precision_ctl_SI = prec;
`endif
        #1;
        checkOutput("reset ready", 64'(bus.Ready_SO), 64'd1);
        checkOutput("reset done", 64'(bus.Done_SO), 64'd0);
        checkOutput("reset quotient", 64'(bus.Quotient_DO), 64'd0);
        checkOutput("reset sticky", 64'(bus.Sticky_SO), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("1/1", ONE, ONE, C_MANT + 2, -1);
        checkOutput("1/1 quotient_const", 64'(bus.Quotient_DO), 64'h20000000000000);
        checkOutput("1/1 sticky_const", 64'(bus.Sticky_SO), 64'd0);

        applyStimulus("1/1.5 busy_start", ONE, ONE_HALF, C_MANT + 2, 5);
        checkOutput("1/1.5 quotient_const", 64'(bus.Quotient_DO), 64'h15555555555555);
        checkOutput("1/1.5 sticky_const", 64'(bus.Sticky_SO), 64'd1);

        applyStimulus("1.5/1", ONE_HALF, ONE, C_MANT + 2, -1);
        checkOutput("1.5/1 quotient_const", 64'(bus.Quotient_DO), 64'h30000000000000);
        applyStimulus("restart 1/1.5", ONE, ONE_HALF, C_MANT + 2, -1);
        checkOutput("restart quotient_const", 64'(bus.Quotient_DO), 64'h15555555555555);

        // Kill during step 20 of a 1.5/1 divide.
        bus.Mant_a_DI = ONE_HALF;
        bus.Mant_b_DI = ONE;
        bus.Start_SI  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start_SI = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        checkOutput("kill busy ready", 64'(bus.Ready_SO), 64'd0);
        bus.Kill_SI = 1'b1;
        @(posedge clk);
        #1;
        bus.Kill_SI = 1'b0;
        checkOutput("kill ready", 64'(bus.Ready_SO), 64'd1);
        checkOutput("kill done", 64'(bus.Done_SO), 64'd0);
        checkOutput("kill quotient_held", 64'(bus.Quotient_DO), 64'(last_quot));
        checkOutput("kill sticky_held", 64'(bus.Sticky_SO), 64'(last_sticky));
        done_seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.Done_SO) done_seen = 1;
        end
        checkOutput("kill no_done", 64'(done_seen), 64'd0);

        // Kill and Start together while idle.
        bus.Mant_a_DI = ONE;
        bus.Mant_b_DI = ONE;
        bus.Start_SI  = 1'b1;
        bus.Kill_SI   = 1'b1;
        @(posedge clk);
        #1;
        bus.Start_SI = 1'b0;
        bus.Kill_SI  = 1'b0;
        checkOutput("kill_start ready", 64'(bus.Ready_SO), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("kill_start ready2", 64'(bus.Ready_SO), 64'd1);
        checkOutput("kill_start done", 64'(bus.Done_SO), 64'd0);

        // Asynchronous reset in the middle of a divide.
        bus.Mant_a_DI = ONE_HALF;
        bus.Mant_b_DI = ONE;
        bus.Start_SI  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start_SI = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset ready", 64'(bus.Ready_SO), 64'd1);
        checkOutput("midreset done", 64'(bus.Done_SO), 64'd0);
        checkOutput("midreset quotient", 64'(bus.Quotient_DO), 64'd0);
        checkOutput("midreset sticky", 64'(bus.Sticky_SO), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postreset quotient", 64'(bus.Quotient_DO), 64'd0);
        applyStimulus("postreset 1/1", ONE, ONE, C_MANT + 2, -1);

`ifdef DIV_ITER_PRECISION_CTL_EN
        prec = 6'd22;
        bus.Precision_ctl_SI = prec;
        applyStimulus("p22 1/1.5", ONE, ONE_HALF, iterFor(prec), -1);
        checkOutput("p22 quotient_const", 64'(bus.Quotient_DO), 64'h15555540000000);
        checkOutput("p22 sticky_const", 64'(bus.Sticky_SO), 64'd1);
        prec = 6'd63;
        bus.Precision_ctl_SI = prec;
        applyStimulus("p63 1/1.5", ONE, ONE_HALF, C_MANT + 2, -1);
        checkOutput("p63 quotient_const", 64'(bus.Quotient_DO), 64'h15555555555555);
`endif

        for (int k = 0; k < 12; k++) begin
            a = randMant();
            b = randMant();
            if (k == 0) b = a;
`ifdef DIV_ITER_PRECISION_CTL_EN
            prec = 6'($urandom_range(0, 63));
            bus.Precision_ctl_SI = prec;
            n = iterFor(prec);
`else
            n = C_MANT + 2;
`endif
            applyStimulus($sformatf("rand%0d", k), a, b, n, ((k % 3) == 1) ? 4 : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/div_iter_ctrl.md
# div_iter_ctrl

Sequential controller for non-restoring mantissa division, one quotient bit per cycle. It sits directly upstream of the per-step add/subtract stage in the div/sqrt datapath. It holds the partial remainder, the divisor and its negation, the quotient shift register and the iteration counter, and it handshakes with the pre-normalisation and rounding stages. Operands arrive normalised: special cases and zero divisors are filtered upstream.

## Interface
- C_MANT, 52 (package constant): mantissa fraction width.
- C_REM_W, C_MANT+3 (package constant): signed remainder width (sign, 2 integer bits, C_MANT fraction bits).
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  reset. One clock; reset is asynchronous and active-low.
- Start_SI  in  1  start request; sampled only while Ready_SO=1.
- Kill_SI  in  1  abort the current operation.
- Mant_a_DI  in  C_MANT+1  dividend with hidden bit; bit C_MANT=1.
- Mant_b_DI  in  C_MANT+1  divisor with hidden bit; bit C_MANT=1.
- Precision_ctl_SI  in  6  iteration control; present only with DIV_ITER_PRECISION_CTL_EN.
- Ready_SO  out  1  high in IDLE.
- Done_SO  out  1  one-cycle pulse; result valid.
- Quotient_DO  out  C_MANT+2  quotient; bit C_MANT+1 has weight 2^0.
- Sticky_SO  out  1  final corrected remainder is non-zero.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE to BUSY: on Start_SI=1 and Kill_SI=0.
  - Load D = Mant_b_DI and negD = -D (two's complement, C_REM_W bits).
  - Load R = Mant_a_DI (sign-extended), Q = 0, counter = 0.
- Each BUSY cycle performs step i = counter:
  - i = 0: R' = R + negD (no shift).
  - i > 0: R' = 2R + negD if R ≥ 0, else 2R + D.
  - q_i = ~R'[C_REM_W-1]. Q shifts left with q_i entering the LSB. counter increments.
- BUSY to DONE: after the step with counter = N-1.
- DONE to IDLE: unconditionally on the next cycle.
- Results:
  - Quotient_DO = Q, with q_0 at the MSB.
  - Sticky_SO = (R ≠ 0) and (R ≠ -D).
  - Both are registered and hold until the next accepted start.
- N = C_MANT+2 (default).
- Kill_SI in BUSY or DONE: return to IDLE next cycle. Done_SO stays 0 and Quotient_DO/Sticky_SO keep their previous values.
- Kill_SI and Start_SI together in IDLE: Kill wins and the start is dropped.
- Start_SI in BUSY or DONE: ignored, not queued.
- The remainder invariant |R| < D < 2 guarantees that 2R + ±D never overflows C_REM_W.

## Timing
- Reset values:
  - state IDLE, so Ready_SO=1.
  - Done_SO=0, Quotient_DO=0, Sticky_SO=0, counter=0, R=0, D=0, negD=0.
- Reset asserted mid-operation: immediate return to IDLE. No Done_SO is emitted.
- Start accepted at the edge ending cycle t: steps occur in cycles t+1..t+N. Done_SO=1 in cycle t+N+1. Ready_SO=1 from cycle t+N+2.
- Default latency: C_MANT+3 = 55 cycles from the start edge to Done_SO.
- Back-to-back: a new start may be sampled in cycle t+N+2 at the earliest.
- Ready_SO and Done_SO are decoded from registered state only; there is no combinational path from any input to any output.

## Configuration
- DIV_ITER_PRECISION_CTL_EN defined:
  - Precision_ctl_SI (p) is sampled at start.
  - N = min(p, C_MANT) + 2.
  - Q is left-aligned after the last step: remaining LSBs are 0 and q_0 stays at the MSB.
  - Sticky_SO comes from the remainder at step N-1.
  - Latency is N+1.
- DIV_ITER_PRECISION_CTL_EN undefined: the port is absent, and N = C_MANT+2 always.

## Structure
- Package fpu_defs_div_sqrt holds:
  - C_MANT and C_REM_W.
  - C_ITER_W = 6.
  - The state enum typedef (IDLE/BUSY/DONE).
- Sub-module div_iter_step (combinational).
  - Inputs: R, D, negD, first-step flag.
  - Outputs: R' and q_i.
  - It contains the shift/select/add. This module keeps the FSM, registers and counter.

## Test plan
- 1.0/1.0 (both Mant = 0x10000000000000): Quotient_DO=0x20000000000000, Sticky_SO=0, Done_SO exactly 55 cycles after start, single-cycle pulse.
- 1.0/1.5 (b = 0x18000000000000): Quotient_DO=0x15555555555555, Sticky_SO=1.
- 1.5/1.0: Quotient_DO=0x30000000000000, Sticky_SO=0. Immediately restart with 1.0/1.5 at first Ready_SO: correct second result and no residue from the first.
- Kill_SI at step 20: IDLE next cycle, no Done_SO, outputs unchanged. Start asserted during BUSY is ignored. Kill+Start in IDLE leaves the block in IDLE.
- Rst_RBI pulsed low mid-BUSY: all outputs return to their reset values asynchronously, then a following 1.0/1.0 divide is correct.
- With DIV_ITER_PRECISION_CTL_EN, p=22, 1.0/1.5: Quotient_DO=0x15555540000000, Sticky_SO=1, Done_SO 25 cycles after start. p=63 behaves as p=52.
